// File: rtl/isp_mosaic_h_if.sv
// Pixel-stream bundle for the RGB-to-Bayer re-mosaic stage.
// The master drives the RGB input side; the slave (the re-mosaic block) drives the RAW output and status side.
interface isp_mosaic_h_if #(
   parameter int BITS = 8
);
   logic            in_href;
   logic            in_vsync;
   logic            in_de;
   logic [BITS-1:0] in_r;
   logic [BITS-1:0] in_g;
   logic [BITS-1:0] in_b;
   logic            out_href;
   logic            out_vsync;
   logic            out_de;
   logic [BITS-1:0] out_raw;
   logic            err_width;
   logic            err_height;

   modport master (
      output in_href, in_vsync, in_de, in_r, in_g, in_b,
      input  out_href, out_vsync, out_de, out_raw, err_width, err_height
   );

   modport slave (
      input  in_href, in_vsync, in_de, in_r, in_g, in_b,
      output out_href, out_vsync, out_de, out_raw, err_width, err_height
   );
endinterface

// File: rtl/isp_mosaic_h.sv
// Re-mosaics an RGB pixel stream into a Bayer RAW stream.
// Also provides an optional horizontal [1 2 1]/4 filter and per-frame width/height checking.
module isp_mosaic_h #(
   parameter int BITS   = 8,
   parameter int WIDTH  = 1280,
   parameter int HEIGHT = 960,
   parameter int BAYER  = 0,
   parameter int LPF    = 0
) (
   input logic           pclk,
   input logic           rst,
   isp_mosaic_h_if.slave bus
);
   localparam int         PW  = $clog2(WIDTH) + 2;
   localparam int         LW  = $clog2(HEIGHT) + 2;
   localparam logic [1:0] PAT = 2'(BAYER);

   typedef struct packed {
      logic [BITS-1:0] r;
      logic [BITS-1:0] g;
      logic [BITS-1:0] b;
   } pix_t;

   typedef struct packed {
      logic       href;
      logic       vsync;
      logic       de;
      logic [1:0] fmt;
      pix_t       pix;
   } stage_t;

   function automatic logic [BITS-1:0] tap3(input logic [BITS-1:0] l, input logic [BITS-1:0] c,
                                            input logic [BITS-1:0] r);
      logic [BITS+1:0] sum;
      sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + (BITS+2)'(2);
      return sum[BITS+1:2];
   endfunction

   logic            odd_pix_q, odd_pix_d;
   logic            odd_line_q, odd_line_d;
   logic            prev_href_q, prev_href_d;
   logic            prev_vsync_q, prev_vsync_d;
   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [LW-1:0]   lcnt_q, lcnt_d;
   logic            line_err_q, line_err_d;
   logic            err_width_q, err_width_d;
   logic            err_height_q, err_height_d;
   stage_t          s1_q, s1_d;
   stage_t          cen;
   logic            out_href_q, out_href_d;
   logic            out_vsync_q, out_vsync_d;
   logic            out_de_q, out_de_d;
   logic [BITS-1:0] out_raw_q, out_raw_d;

   logic            fall, vrise, line_err_n;
   logic [LW-1:0]   lcnt_n;

   always_comb begin
      fall  = prev_href_q & ~bus.in_href;
      vrise = ~prev_vsync_q & bus.in_vsync;

      odd_pix_d    = bus.in_href & ~odd_pix_q;
      odd_line_d   = bus.in_vsync ? 1'b0 : (odd_line_q ^ fall);
      prev_href_d  = bus.in_href;
      prev_vsync_d = bus.in_vsync;

      // pcnt holds the index of the newest pixel, so the line length at the falling edge is pcnt+1
      pcnt_d = '0;
      if (bus.in_href && prev_href_q) begin
         pcnt_d = (pcnt_q != '1) ? pcnt_q + PW'(1) : pcnt_q;
      end

      line_err_n = line_err_q | (fall && (int'(pcnt_q) + 1 != WIDTH));
      lcnt_n     = (fall && lcnt_q != '1) ? lcnt_q + LW'(1) : lcnt_q;

      // a line ending on the vsync edge itself belongs to the frame being closed
      line_err_d   = line_err_n;
      lcnt_d       = lcnt_n;
      err_width_d  = err_width_q;
      err_height_d = err_height_q;
      if (vrise && lcnt_n != '0) begin
         err_width_d  = line_err_n;
         err_height_d = (int'(lcnt_n) != HEIGHT);
         line_err_d   = 1'b0;
         lcnt_d       = '0;
      end

      s1_d.href  = bus.in_href;
      s1_d.vsync = bus.in_vsync;
      s1_d.de    = bus.in_de;
      s1_d.fmt   = PAT ^ {odd_line_q, odd_pix_q};
      s1_d.pix.r = bus.in_r;
      s1_d.pix.g = bus.in_g;
      s1_d.pix.b = bus.in_b;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         odd_pix_q    <= 1'b0;
         odd_line_q   <= 1'b0;
         prev_href_q  <= 1'b0;
         prev_vsync_q <= 1'b0;
         pcnt_q       <= '0;
         lcnt_q       <= '0;
         line_err_q   <= 1'b0;
         err_width_q  <= 1'b0;
         err_height_q <= 1'b0;
         s1_q         <= '0;
      end else begin
         odd_pix_q    <= odd_pix_d;
         odd_line_q   <= odd_line_d;
         prev_href_q  <= prev_href_d;
         prev_vsync_q <= prev_vsync_d;
         pcnt_q       <= pcnt_d;
         lcnt_q       <= lcnt_d;
         line_err_q   <= line_err_d;
         err_width_q  <= err_width_d;
         err_height_q <= err_height_d;
         s1_q         <= s1_d;
      end
   end

   generate
      if (LPF != 0) begin : g_lpf
         stage_t s2_q, s2_d;
         logic   left_h_q, left_h_d;
         pix_t   left_q, left_d;
         pix_t   lft, rgt;

         // s1 is the right neighbour, s2 the centre, left the previous centre; href gaps force replication
         always_comb begin
            s2_d     = s1_q;
            left_h_d = s2_q.href;
            left_d   = s2_q.pix;
            lft      = left_h_q  ? left_q   : s2_q.pix;
            rgt      = s1_q.href ? s1_q.pix : s2_q.pix;
            cen       = s2_q;
            cen.pix.r = tap3(lft.r, s2_q.pix.r, rgt.r);
            cen.pix.g = tap3(lft.g, s2_q.pix.g, rgt.g);
            cen.pix.b = tap3(lft.b, s2_q.pix.b, rgt.b);
         end

         always_ff @(posedge pclk) begin
            if (rst) begin
               s2_q     <= '0;
               left_h_q <= 1'b0;
               left_q   <= '0;
            end else begin
               s2_q     <= s2_d;
               left_h_q <= left_h_d;
               left_q   <= left_d;
            end
         end
      end else begin : g_direct
         always_comb cen = s1_q;
      end
   endgenerate

   always_comb begin
      out_href_d  = cen.href;
      out_vsync_d = cen.vsync;
      out_de_d    = cen.de;
      case (cen.fmt)
         2'd0:    out_raw_d = cen.pix.r;
         2'd1,
         2'd2:    out_raw_d = cen.pix.g;
         default: out_raw_d = cen.pix.b;
      endcase
      if (!cen.href) out_raw_d = '0;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         out_href_q  <= 1'b0;
         out_vsync_q <= 1'b0;
         out_de_q    <= 1'b0;
         out_raw_q   <= '0;
      end else begin
         out_href_q  <= out_href_d;
         out_vsync_q <= out_vsync_d;
         out_de_q    <= out_de_d;
         out_raw_q   <= out_raw_d;
      end
   end

   assign bus.out_href   = out_href_q;
   assign bus.out_vsync  = out_vsync_q;
   assign bus.out_de     = out_de_q;
   assign bus.out_raw    = out_raw_q;
   assign bus.err_width  = err_width_q;
   assign bus.err_height = err_height_q;
endmodule
